// File: rtl/serial_seq_detector.sv
// serial_seq_detector: overlapping serial PATTERN matcher (clk, reset_n-style reset, en, data, clear -> match pulse, saturating match_cnt, shreg history)
module serial_seq_detector #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          data,
  input  logic          clear,
  output logic          match,
  output logic [CW-1:0] match_cnt,
  output logic [N-1:0]  shreg
);
  localparam int FW = $clog2(N + 1);
  logic [FW-1:0] fill;
  logic [N-1:0]  nxt;
  logic          hit;
  assign nxt = {shreg[N-2:0], data};
  assign hit = (fill >= FW'(N - 1)) && (nxt == PATTERN);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shreg     <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (clear) begin
      shreg     <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (en) begin
      shreg <= nxt;
      fill  <= (fill == FW'(N)) ? fill : fill + 1'b1;
      match <= hit;
      if (hit && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
    end else begin
      match <= 1'b0;
    end
endmodule

// File: tb/tb_serial_seq_detector.sv
// tb_serial_seq_detector: directed and random checks of serial_seq_detector against a bit-history model
module tb_serial_seq_detector;
  localparam int N = 4;
  localparam int CW = 4;
  localparam logic [N-1:0] PAT = 4'b1011;
  logic clk = 0, reset = 0, en = 0, data = 0, clear = 0;
  logic match;
  logic [CW-1:0] match_cnt;
  logic [N-1:0] shreg;
  int checks = 0, failures = 0, pulses = 0, m_cnt = 0;
  logic m_match = 0;
  bit hist[$];
  serial_seq_detector #(.N(N), .PATTERN(PAT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .data(data), .clear(clear),
    .match(match), .match_cnt(match_cnt), .shreg(shreg)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N-1:0] m_shreg();
    logic [N-1:0] s = '0;
    int k = hist.size();
    for (int i = 0; i < N && i < k; i++) s[i] = hist[k-1-i];
    return s;
  endfunction
  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    m_match = 0;
  endtask
  task automatic step(input logic e, input logic d, input logic c);
    en = e;
    data = d;
    clear = c;
    @(posedge clk);
    if (c) model_reset();
    else if (e) begin
      hist.push_back(d);
      if (hist.size() > 64) void'(hist.pop_front());
      m_match = hist.size() >= N && m_shreg() == PAT;
      if (m_match && m_cnt < 2**CW - 1) m_cnt++;
    end else m_match = 0;
    #1;
    if (match) pulses++;
    check("match", match, m_match);
    check("match_cnt", match_cnt, m_cnt);
    check("shreg", shreg, m_shreg());
  endtask
  task automatic feed(input logic [6:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i], 0);
  endtask
  task automatic async_reset();
    #4 reset = 0;
    #1;
    model_reset();
    check("async_match", match, 0);
    check("async_cnt", match_cnt, 0);
    check("async_shreg", shreg, 0);
    #4 reset = 1;
  endtask
  initial begin
    #1;
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_shreg", shreg, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    feed(7'b1011, 4);
    check("t1_match", match, 1);
    check("t1_shreg", shreg, 4'b1011);
    step(0, 0, 0);
    check("t1_pulse_end", match, 0);
    step(0, 0, 1);
    pulses = 0;
    feed(7'b1011011, 7);
    check("t2_pulses", pulses, 2);
    check("t2_cnt", match_cnt, 2);
    step(0, 0, 1);
    pulses = 0;
    step(1, 1, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0);
    step(1, 1, 0); step(0, 1, 0);
    step(1, 1, 0);
    check("t3_match", match, 1);
    step(0, 1, 0);
    check("t3_pulses", pulses, 1);
    step(0, 0, 1);
    feed(7'b101, 3);
    step(1, 0, 1);
    step(1, 1, 0);
    check("t4_shreg", shreg, 4'b0001);
    check("t4_cnt", match_cnt, 0);
    check("t4_match", match, 0);
    step(0, 0, 1);
    pulses = 0;
    repeat (20) feed(7'b1011, 4);
    check("t5_pulses", pulses, 20);
    check("t5_cnt", match_cnt, 15);
    step(0, 0, 1);
    feed(7'b1011011, 7);
    check("t6_pre_cnt", match_cnt, 2);
    async_reset();
    feed(7'b011, 3);
    check("t6_fill_guard", match, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) async_reset();
      step($urandom_range(3) != 0, $urandom_range(1), $urandom_range(79) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
